// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM state encoding and link mode constants.
// The Nios-side slave and the benches import the same package so both ends
// agree on clock polarity, phase and bit order.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER_HI,
    XFER_LO,
    HOLD,
    GAP
  } spi_state_t;

  // Mode 0, MSB first.
  localparam bit CPOL      = 1'b0;
  localparam bit CPHA      = 1'b0;
  localparam bit MSB_FIRST = 1'b1;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Phase timer for the SPI master: a down-counter that fires a one-cycle tick
// every CLK_DIV enabled cycles. Clear reloads the count so the first phase
// after leaving IDLE lasts exactly CLK_DIV cycles.
module spi_tick_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = cnt_width(CLK_DIV);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_div_check
    $error("spi_tick_gen: CLK_DIV must be >= 1");
  end

  logic [CNT_W-1:0] cnt;

  // Down-count with reload on terminal count; clear wins over enable.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (enable) begin
      if (cnt == '0) begin
        cnt <= LOAD;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign tick = enable && !clear && (cnt == '0);

endmodule

// File: rtl/spi_master_32.sv
// SPI mode-0 master issuing DATA_W-bit, MSB-first, full-duplex frames.
// Every output is a register; phases advance on ticks from spi_tick_gen.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | CS high, waiting for iSTART
//   SETUP   | CS low, first MOSI bit presented, SCLK low
//   XFER_HI | SCLK high; MISO sampled on the first cycle of the phase
//   XFER_LO | SCLK low; next MOSI bit presented on the first cycle
//   HOLD    | CS still low after the last falling edge
//   GAP     | CS high, still busy; minimum deassert time before next frame
module spi_master_32
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSTART,
  input  logic [DATA_W-1:0] iTX_DATA,
  output logic [DATA_W-1:0] oRX_DATA,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oSPI_CLK,
  output logic              oSPI_CS,
  output logic              oSPI_MOSI,
  input  logic              iSPI_MISO
);

  localparam int BIT_W = cnt_width(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  if (DATA_W < 2) begin : g_width_check
    $error("spi_master_32: DATA_W must be >= 2");
  end

  spi_state_t        state;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [BIT_W-1:0]  bit_cnt;
  logic              phase_first;
  logic              tick;
  logic              tick_en;
  logic              tick_clr;
  logic              accept;

  assign tick_en  = (state != IDLE);
  assign tick_clr = (state == IDLE);

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk_sys(iCLK),
    .rst    (iRST),
    .enable (tick_en),
    .clear  (tick_clr),
    .tick   (tick)
  );

  // A frame may start from IDLE, or directly at the end of GAP so that a
  // held iSTART gives back-to-back frames with only the GAP between them.
  assign accept = iSTART && ((state == IDLE) || ((state == GAP) && tick));

  // Frame sequencer, shift registers and registered link outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state       <= IDLE;
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      phase_first <= 1'b0;
      oRX_DATA    <= '0;
      oBUSY       <= 1'b0;
      oDONE       <= 1'b0;
      oSPI_CLK    <= CPOL;
      oSPI_CS     <= 1'b1;
      oSPI_MOSI   <= 1'b0;
    end else begin
      oDONE       <= 1'b0;
      phase_first <= 1'b0;
      if (accept) begin
        tx_sr       <= iTX_DATA;
        oSPI_MOSI   <= iTX_DATA[DATA_W-1];
        oSPI_CS     <= 1'b0;
        oSPI_CLK    <= CPOL;
        oBUSY       <= 1'b1;
        bit_cnt     <= '0;
        phase_first <= 1'b1;
        state       <= SETUP;
      end else begin
        case (state)
          IDLE: begin
            oSPI_CS  <= 1'b1;
            oSPI_CLK <= CPOL;
          end
          SETUP: begin
            if (tick) begin
              oSPI_CLK    <= ~CPOL;
              phase_first <= 1'b1;
              state       <= XFER_HI;
            end
          end
          XFER_HI: begin
            if (phase_first) begin
              rx_sr <= {rx_sr[DATA_W-2:0], iSPI_MISO};
            end
            if (tick) begin
              oSPI_CLK    <= CPOL;
              phase_first <= 1'b1;
              state       <= XFER_LO;
            end
          end
          XFER_LO: begin
            // The last bit is left on MOSI; nothing follows it.
            if (phase_first && (bit_cnt != LAST_BIT)) begin
              tx_sr     <= tx_sr << 1;
              oSPI_MOSI <= tx_sr[DATA_W-2];
            end
            if (tick) begin
              phase_first <= 1'b1;
              if (bit_cnt == LAST_BIT) begin
                state <= HOLD;
              end else begin
                bit_cnt  <= bit_cnt + BIT_W'(1);
                oSPI_CLK <= ~CPOL;
                state    <= XFER_HI;
              end
            end
          end
          HOLD: begin
            if (tick) begin
              oSPI_CS     <= 1'b1;
              oDONE       <= 1'b1;
              oRX_DATA    <= rx_sr;
              phase_first <= 1'b1;
              state       <= GAP;
            end
          end
          GAP: begin
            if (tick) begin
              oBUSY <= 1'b0;
              state <= IDLE;
            end
          end
          default: begin
            oSPI_CS  <= 1'b1;
            oSPI_CLK <= CPOL;
            oBUSY    <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master_32.sv
// Directed and randomized bench for spi_master_32: one instance at the
// default divider with a loopback or behavioural slave on MISO, and one at
// CLK_DIV=1 in loopback with iSTART held high.
module tb_spi_master_32;

  localparam int W     = 32;
  localparam int DIV_A = 4;
  localparam int DIV_B = 1;
  localparam int TD_A  = 1 + DIV_A * (2 * W + 2);
  localparam int TD_B  = 1 + DIV_B * (2 * W + 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_a, start_b;
  logic [W-1:0] tx_a, tx_b, rx_a, rx_b;
  logic         busy_a, done_a, sclk_a, cs_a, mosi_a, miso_a;
  logic         busy_b, done_b, sclk_b, cs_b, mosi_b;
  logic         loop_a, slave_bit;

  assign miso_a = loop_a ? mosi_a : slave_bit;

  spi_master_32 #(.CLK_DIV(DIV_A), .DATA_W(W)) dut_a (
    .iCLK(clk), .iRST(rst), .iSTART(start_a), .iTX_DATA(tx_a),
    .oRX_DATA(rx_a), .oBUSY(busy_a), .oDONE(done_a), .oSPI_CLK(sclk_a),
    .oSPI_CS(cs_a), .oSPI_MOSI(mosi_a), .iSPI_MISO(miso_a)
  );

  spi_master_32 #(.CLK_DIV(DIV_B), .DATA_W(W)) dut_b (
    .iCLK(clk), .iRST(rst), .iSTART(start_b), .iTX_DATA(tx_b),
    .oRX_DATA(rx_b), .oBUSY(busy_b), .oDONE(done_b), .oSPI_CLK(sclk_b),
    .oSPI_CS(cs_b), .oSPI_MOSI(mosi_b), .iSPI_MISO(mosi_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] slave_word, slave_tx, slave_rx;
  logic p_sclk_a, p_mosi_a, p_cs_a, p_busy_a, p_cs_b;
  int rises_a, viol_a, done_cnt_a, done_cyc_a, busy_fall_a, cs_fall_a, cs_low_post_a;
  logic [W-1:0] done_rx_a;
  int done_cnt_b, cs_gap_b, cs_fall_b;
  int done_cyc_b [2];
  logic [W-1:0] done_rx_b [2];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    cyc = 0;
    rises_a = 0; viol_a = 0; done_cnt_a = 0; done_cyc_a = -1;
    busy_fall_a = -1; cs_fall_a = 0; cs_low_post_a = 0; done_rx_a = '0;
    done_cnt_b = 0; cs_gap_b = 0; cs_fall_b = 0;
    done_cyc_b[0] = -1; done_cyc_b[1] = -1;
    done_rx_b[0] = '0; done_rx_b[1] = '0;
    p_sclk_a = sclk_a; p_mosi_a = mosi_a; p_cs_a = cs_a; p_busy_a = busy_a;
    p_cs_b = cs_b;
    slave_tx = slave_word; slave_rx = '0; slave_bit = slave_word[W-1];
  endtask

  // One clock; sample 1 time unit after the edge and update the protocol model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (p_sclk_a && sclk_a && (mosi_a !== p_mosi_a)) viol_a++;
    if (p_cs_a && !cs_a) begin
      cs_fall_a++;
      slave_tx  = slave_word;
      slave_bit = slave_word[W-1];
    end
    if (!p_sclk_a && sclk_a) begin
      rises_a++;
      slave_rx = {slave_rx[W-2:0], mosi_a};
    end
    if (p_sclk_a && !sclk_a && !cs_a) begin
      slave_tx  = slave_tx << 1;
      slave_bit = slave_tx[W-1];
    end
    if (done_a) begin
      done_cnt_a++;
      if (done_cnt_a == 1) begin
        done_cyc_a = cyc;
        done_rx_a  = rx_a;
      end
    end
    if ((done_cnt_a > 0) && !cs_a) cs_low_post_a++;
    if (p_busy_a && !busy_a && (busy_fall_a < 0)) busy_fall_a = cyc;
    if (p_cs_b && !cs_b) cs_fall_b++;
    if (done_b) begin
      if (done_cnt_b < 2) begin
        done_cyc_b[done_cnt_b] = cyc;
        done_rx_b[done_cnt_b]  = rx_b;
      end
      done_cnt_b++;
    end
    if (cs_b && (done_cnt_b >= 1) && (cs_fall_b == 1)) cs_gap_b++;
    p_sclk_a = sclk_a; p_mosi_a = mosi_a; p_cs_a = cs_a; p_busy_a = busy_a;
    p_cs_b = cs_b;
  endtask

  // Start a frame on dut_a (the next edge is cycle 0) and run n sampled cycles.
  task automatic run_frame_a(input logic [W-1:0] word, input logic loop,
                             input logic [W-1:0] sw, input int n);
    loop_a     = loop;
    slave_word = sw;
    tx_a       = word;
    start_a    = 1'b1;
    clear_mon();
    tick();
    start_a = 1'b0;
    repeat (n - 1) tick();
  endtask

  logic [W-1:0] w, s;

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    tx_a = '0; tx_b = '0; loop_a = 1'b1; slave_bit = 1'b0; slave_word = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs",   W'(cs_a),   1);
    check("rst_sclk", W'(sclk_a), 0);
    check("rst_mosi", W'(mosi_a), 0);
    check("rst_busy", W'(busy_a), 0);
    check("rst_done", W'(done_a), 0);
    check("rst_rx",   rx_a,       0);
    check("rst_cs_b", W'(cs_b),   1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Loopback
    run_frame_a(32'hA5A5_1234, 1'b1, '0, TD_A + DIV_A + 6);
    check("lb_rx",        done_rx_a,   32'hA5A5_1234);
    check("lb_done_cyc",  done_cyc_a,  TD_A);
    check("lb_busy_fall", busy_fall_a, TD_A + DIV_A);
    check("lb_rises",     rises_a,     W);
    check("lb_done_cnt",  done_cnt_a,  1);
    check("lb_mosi_stab", viol_a,      0);

    // Behavioural slave returning DEADBEEF
    run_frame_a(32'h0000_00FF, 1'b0, 32'hDEAD_BEEF, TD_A + DIV_A + 6);
    check("sl_mosi_seen", slave_rx,   32'h0000_00FF);
    check("sl_rx",        rx_a,       32'hDEAD_BEEF);
    check("sl_mosi_stab", viol_a,     0);
    check("sl_done_cyc",  done_cyc_a, TD_A);

    // Random words through the slave model
    for (int k = 0; k < 3; k++) begin
      w = $urandom;
      s = $urandom;
      run_frame_a(w, 1'b0, s, TD_A + DIV_A + 6);
      check("rnd_mosi_seen", slave_rx,   w);
      check("rnd_rx",        done_rx_a,  s);
      check("rnd_done_cnt",  done_cnt_a, 1);
      check("rnd_mosi_stab", viol_a,     0);
    end

    // iSTART pulses and iTX_DATA changes during a frame are ignored
    w = $urandom;
    loop_a = 1'b1; tx_a = w; start_a = 1'b1;
    clear_mon();
    tick();
    start_a = 1'b0;
    while (cyc < 300) begin
      tick();
      if ((cyc == 50) || (cyc == 200)) begin
        start_a = 1'b1;
        tx_a    = $urandom;
      end else begin
        start_a = 1'b0;
      end
    end
    check("ign_done_cnt", done_cnt_a,    1);
    check("ign_done_cyc", done_cyc_a,    TD_A);
    check("ign_cs_falls", cs_fall_a,     1);
    check("ign_cs_high",  cs_low_post_a, 0);
    check("ign_busy",     W'(busy_a),    0);
    check("ign_mosi",     slave_rx,      w);
    check("ign_rx",       rx_a,          w);

    // Reset at the 10th rising SCLK edge
    w = $urandom;
    loop_a = 1'b1; tx_a = w; start_a = 1'b1;
    clear_mon();
    tick();
    start_a = 1'b0;
    while ((rises_a < 10) && (cyc < 200)) tick();
    check("mid_rises", rises_a, 10);
    rst = 1'b1;
    tick();
    check("mid_cs",   W'(cs_a),   1);
    check("mid_sclk", W'(sclk_a), 0);
    check("mid_busy", W'(busy_a), 0);
    check("mid_rx",   rx_a,       0);
    check("mid_done", W'(done_a), 0);
    rst = 1'b0;
    repeat (300) tick();
    check("mid_no_done", done_cnt_a, 0);
    w = $urandom;
    run_frame_a(w, 1'b1, '0, TD_A + DIV_A + 6);
    check("mid_fresh_rx",   done_rx_a,  w);
    check("mid_fresh_done", done_cyc_a, TD_A);

    // CLK_DIV=1, iSTART held, loopback
    tx_b = 32'h0000_0001;
    start_b = 1'b1;
    clear_mon();
    tick();
    tx_b = 32'h8000_0000;
    while (cyc < 2 * TD_B + 12) begin
      tick();
      if (cyc == TD_B + 1) start_b = 1'b0;
    end
    check("b2b_done_cnt", done_cnt_b,    2);
    check("b2b_done0",    done_cyc_b[0], TD_B);
    check("b2b_done1",    done_cyc_b[1], 2 * TD_B);
    check("b2b_rx0",      done_rx_b[0],  32'h0000_0001);
    check("b2b_rx1",      done_rx_b[1],  32'h8000_0000);
    check("b2b_cs_gap",   cs_gap_b,      1);
    check("b2b_busy_end", W'(busy_b),    0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_32.md
Name: spi_master_32

Overview:
- SPI mode-0 master that issues 32-bit, MSB-first, full-duplex frames.
- It is the initiating end of the same 4-wire link used between the Pi and the Nios-side SPI slave (SCLK, CE0, MOSI, MISO).
- It drives the on-board loopback and self-test of that slave path.
- It lets FPGA logic act as master to external SPI peripherals on GPIO_0.

Parameters:
- CLK_DIV, 4: iCLK cycles per SCLK half-period; must be >= 1 (elaboration-time assertion).
- DATA_W, 32: frame length in bits; must be >= 2.

Ports:
- iCLK  input  1  system clock (CLOCK_50 domain)
- iRST  input  1  reset, synchronous, active-high
- iSTART  input  1  request a frame; sampled only in IDLE
- iTX_DATA  input  DATA_W  word to send; captured on the accepted iSTART cycle
- oRX_DATA  output  DATA_W  last received word; valid from oDONE onward
- oBUSY  output  1  high from the cycle after start acceptance until return to IDLE
- oDONE  output  1  one-cycle pulse when a frame completes
- oSPI_CLK  output  1  SCLK, idle low
- oSPI_CS  output  1  chip select, active low, idle high
- oSPI_MOSI  output  1  serial data out
- iSPI_MISO  input  1  serial data in; already synchronised by the instantiating level

Behaviour:
- Clock and reset: one clock (iCLK). Reset is synchronous and active-high (iRST).
- Reset values:
  - oSPI_CS=1, oSPI_CLK=0, oSPI_MOSI=0
  - oBUSY=0, oDONE=0, oRX_DATA=0
  - state IDLE, all counters 0
- States: IDLE, SETUP, XFER_HI, XFER_LO, HOLD, GAP.
- Divider counter: 0..CLK_DIV-1, width $clog2(CLK_DIV) (minimum 1 bit).
- Bit counter: 0..DATA_W-1.
- Timing below is relative to cycle 0, the edge at which iSTART=1 is sampled in IDLE.
- IDLE: on iSTART, latch iTX_DATA into the tx shift register and go to SETUP.
- SETUP, cycles 1..CLK_DIV:
  - oSPI_CS=0, oBUSY=1, oSPI_MOSI=tx[DATA_W-1], oSPI_CLK=0.
- XFER_HI, CLK_DIV cycles:
  - oSPI_CLK=1.
  - On the first cycle of the phase, shift iSPI_MISO into rx[0] (rx shifts left).
- XFER_LO, CLK_DIV cycles:
  - oSPI_CLK=0.
  - On the first cycle of the phase, the tx register shifts left and MOSI presents the next bit.
  - No MOSI shift follows the last bit.
  - After bit DATA_W-1 go to HOLD; otherwise go back to XFER_HI.
- MOSI never changes while oSPI_CLK=1.
- Exactly DATA_W rising SCLK edges occur per frame.
- HOLD: CLK_DIV cycles with CS=0 and SCLK=0.
- Completion, at cycle Td = 1 + CLK_DIV*(2*DATA_W+2):
  - oSPI_CS=1, oDONE=1 for exactly one cycle.
  - oRX_DATA loads the rx shift register and holds it until the next oDONE or reset.
  - State enters GAP.
- GAP: CLK_DIV cycles (including Td) with CS high and oBUSY still 1. This guarantees a minimum CS-deassert time.
- Return to IDLE: at cycle Td + CLK_DIV, oBUSY=0 and a new iSTART may be accepted that same cycle.
- Default timing (CLK_DIV=4, DATA_W=32): oDONE at cycle 265, oBUSY low at cycle 269, SCLK = 6.25 MHz.
- iSTART while oBUSY=1: ignored, not queued. iTX_DATA changes during a frame have no effect.
- iSTART held high continuously produces back-to-back frames, each separated by the GAP.
- iRST mid-frame: on the next edge CS=1, SCLK=0, state IDLE, oRX_DATA=0, and no oDONE pulse.
- iRST has priority over iSTART on the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- spi_pkg holds the state enum (spi_state_t) and the mode constants CPOL=0, CPHA=0, MSB_FIRST=1. The Nios-side slave and test benches share these.
- Sub-module spi_tick_gen: parameter CLK_DIV.
  - Inputs: enable, clear.
  - Output: a one-cycle tick every CLK_DIV enabled cycles.
  - The FSM advances phases on ticks.
- The FSM and shift registers stay in spi_master_32.

Test Plan:
- Loopback: MOSI tied to MISO, iTX_DATA=32'hA5A5_1234, start at cycle 0.
  - oRX_DATA=32'hA5A5_1234 and oDONE at cycle 265.
  - oBUSY falls at cycle 269.
  - Exactly 32 SCLK rising edges.
- Slave model returning 32'hDEAD_BEEF while checking received MOSI 32'h0000_00FF:
  - Model sees 32'h0000_00FF.
  - oRX_DATA=32'hDEAD_BEEF.
  - MOSI stable across every SCLK-high interval.
- iSTART pulsed at cycles 50 and 200 during a frame:
  - Ignored: single oDONE at 265, no second frame, CS stays high from 265 to 269+.
- iRST asserted at the 10th SCLK rising edge:
  - Next cycle CS=1, SCLK=0, oBUSY=0, oRX_DATA=0.
  - No oDONE; a fresh frame afterwards completes normally.
- CLK_DIV=1, iSTART held high, tx words 32'h1 then 32'h8000_0000 in loopback:
  - oDONE at cycles 67 and 134.
  - oRX_DATA 32'h1 then 32'h8000_0000.
  - CS high for exactly 1 cycle between frames.
- Reset-value check: outputs after iRST=1 are CS=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, RX=0.
